// File: rtl/n64_transmit_frame_if.sv
// Frame-request / serial-line bundle between command logic and the N64 frame transmitter.
interface n64_transmit_frame_if #(
  parameter int DATA_W = 64
);
  localparam int NB_W = $clog2(DATA_W + 1);

  logic              start;
  logic [DATA_W-1:0] data;
  logic [NB_W-1:0]   nbits;
  logic              stop_sel;
  logic              n64d;
  logic              busy;
  logic              done;

  modport master (
    output start, data, nbits, stop_sel,
    input  n64d, busy, done
  );

  modport slave (
    input  start, data, nbits, stop_sel,
    output n64d, busy, done
  );
endinterface

// File: rtl/n64_transmit_frame.sv
// N64/GameCube frame transmitter: nbits data bits MSB-first plus console/controller stop bit.
// Optional post-stop idle guard enabled by defining N64TX_GUARD_EN.
module n64_transmit_frame #(
  parameter int CLK_HZ   = 50000000,
  parameter int DATA_W   = 64,
  parameter int GUARD_US = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  n64_transmit_frame_if.slave  tx
);
  localparam int US        = CLK_HZ / 1000000;
  localparam int NB_W      = $clog2(DATA_W + 1);
  localparam int GUARD_CYC = GUARD_US * US;
  localparam int CNT_W     = (GUARD_CYC > 4 * US) ? $clog2(GUARD_CYC + 1) : $clog2(4 * US + 1);

  // Counters hold "cycles remaining minus one" so a phase ends when cnt hits zero.
  localparam logic [CNT_W-1:0] C_1US = CNT_W'(US - 1);
  localparam logic [CNT_W-1:0] C_2US = CNT_W'(2 * US - 1);
  localparam logic [CNT_W-1:0] C_3US = CNT_W'(3 * US - 1);
  localparam logic [NB_W-1:0]  NB_MAX = NB_W'(DATA_W);

`ifdef N64TX_GUARD_EN
  localparam logic [CNT_W-1:0] C_GUARD = CNT_W'(GUARD_CYC - 1);
  typedef enum logic [2:0] {IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, GUARD} state_t;
`else
  typedef enum logic [1:0] {IDLE, BIT_LOW, BIT_HIGH, STOP_LOW} state_t;
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sr;
  logic [NB_W-1:0]   bits_left;
  logic              stop_q;
  logic              n64d_q;
  logic              busy_q;
  logic              done_q;

  logic [NB_W-1:0]   n_clamp;
  logic [DATA_W-1:0] load_sr;

  // Left-justify the payload so the first bit to send sits in the MSB.
  assign n_clamp = (tx.nbits > NB_MAX) ? NB_MAX : tx.nbits;
  assign load_sr = tx.data << (NB_MAX - n_clamp);

  assign tx.n64d = n64d_q;
  assign tx.busy = busy_q;
  assign tx.done = done_q;

  function automatic logic [CNT_W-1:0] low_len(input logic b);
    return b ? C_1US : C_3US;
  endfunction

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      bits_left <= '0;
      stop_q    <= 1'b0;
      n64d_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is deliberately dropped.
          if (tx.start && !done_q) begin
            sr        <= load_sr;
            bits_left <= n_clamp;
            stop_q    <= tx.stop_sel;
            busy_q    <= 1'b1;
            n64d_q    <= 1'b0;
            if (n_clamp == '0) begin
              state <= STOP_LOW;
              cnt   <= tx.stop_sel ? C_2US : C_1US;
            end else begin
              state <= BIT_LOW;
              cnt   <= low_len(load_sr[DATA_W-1]);
            end
          end
        end
        BIT_LOW: begin
          if (cnt == '0) begin
            state  <= BIT_HIGH;
            n64d_q <= 1'b1;
            cnt    <= low_len(~sr[DATA_W-1]);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        BIT_HIGH: begin
          if (cnt == '0) begin
            sr        <= sr << 1;
            bits_left <= bits_left - NB_W'(1);
            n64d_q    <= 1'b0;
            if (bits_left == NB_W'(1)) begin
              state <= STOP_LOW;
              cnt   <= stop_q ? C_2US : C_1US;
            end else begin
              state <= BIT_LOW;
              cnt   <= low_len(sr[DATA_W-2]);
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STOP_LOW: begin
          if (cnt == '0) begin
            n64d_q <= 1'b1;
`ifdef N64TX_GUARD_EN
            state  <= GUARD;
            cnt    <= C_GUARD;
`else
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef N64TX_GUARD_EN
        GUARD: begin
          if (cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_n64_transmit_frame.sv
// Bench for n64_transmit_frame: per-cycle waveform model plus literal pulse/length checks.
module tb_n64_transmit_frame;
  localparam int CLK_HZ = 50000000;
  localparam int DATA_W = 64;
  localparam int US     = CLK_HZ / 1000000;
`ifdef N64TX_GUARD_EN
  localparam int GUARD_CYC = 2 * US;
`else
  localparam int GUARD_CYC = 0;
`endif
  localparam logic [2:0] IDLE_OUT = 3'b100;  // {n64d, busy, done}

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  n64_transmit_frame_if #(.DATA_W(DATA_W)) tx ();

  n64_transmit_frame #(
    .CLK_HZ  (CLK_HZ),
    .DATA_W  (DATA_W),
    .GUARD_US(2)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .tx     (tx.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted frame expands into its per-cycle {n64d,busy,done} sequence.
  logic [2:0] exp_q[$];
  logic [2:0] cur_exp = IDLE_OUT;

  task automatic push_frame(input logic [63:0] d, input int n, input logic ss);
    int nn;
    int l;
    nn = (n > DATA_W) ? DATA_W : n;
    for (int i = nn - 1; i >= 0; i--) begin
      l = d[i] ? US : 3 * US;
      repeat (l) exp_q.push_back(3'b010);
      repeat (4 * US - l) exp_q.push_back(3'b110);
    end
    repeat (US * (1 + int'(ss))) exp_q.push_back(3'b010);
    repeat (GUARD_CYC) exp_q.push_back(3'b110);
    exp_q.push_back(3'b101);
  endtask

  always @(posedge sys_clk) begin
    if (rst) begin
      exp_q.delete();
      cur_exp = IDLE_OUT;
    end else begin
      if (tx.start && !cur_exp[1] && !cur_exp[0])
        push_frame(tx.data, int'(tx.nbits), tx.stop_sel);
      cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_OUT;
    end
  end

  // Compare every cycle, and record low-pulse widths and frame length.
  int cyc = 0;
  int run = 0;
  int first_low = -1;
  int done_cyc = -1;
  int pulses[$];

  always @(negedge sys_clk) begin
    cyc++;
    check("cycle_out", {61'd0, tx.n64d, tx.busy, tx.done}, {61'd0, (rst ? IDLE_OUT : cur_exp)});
    if (!rst) begin
      if (tx.n64d == 1'b0) begin
        run++;
        if (first_low < 0) first_low = cyc;
      end else if (run > 0) begin
        pulses.push_back(run);
        run = 0;
      end
      if (tx.done) done_cyc = cyc;
    end
  end

  function automatic int pulse(input int i);
    if (i < pulses.size()) return pulses[i];
    return -1;
  endfunction

  task automatic wait_done();
    int k = 0;
    while (!tx.done && k < 20000) begin
      @(negedge sys_clk);
      k++;
    end
    check("done_seen", {63'd0, tx.done}, 64'd1);
  endtask

  task automatic send(input logic [63:0] d, input int n, input logic ss);
    @(negedge sys_clk);
    tx.data     = d;
    tx.nbits    = 7'(n);
    tx.stop_sel = ss;
    tx.start    = 1'b1;
    first_low   = -1;
    done_cyc    = -1;
    pulses.delete();
    @(negedge sys_clk);
    tx.start = 1'b0;
    check("busy_latency", {62'd0, tx.busy, tx.n64d}, 64'b10);
    wait_done();
    @(negedge sys_clk);
  endtask

  initial begin
    int k;
    rst         = 1'b1;
    tx.start    = 1'b0;
    tx.data     = '0;
    tx.nbits    = '0;
    tx.stop_sel = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_state", {61'd0, tx.n64d, tx.busy, tx.done}, 64'b100);
    #2 rst = 1'b0;

    // Async reset in the middle of a 0-bit low phase.
    @(negedge sys_clk);
    tx.data = 64'h01; tx.nbits = 7'd8; tx.stop_sel = 1'b0; tx.start = 1'b1;
    @(negedge sys_clk);
    tx.start = 1'b0;
    repeat (30) @(negedge sys_clk);
    check("mid_bit_low", {63'd0, tx.n64d}, 64'd0);
    #2 rst = 1'b1;
    #1 check("async_reset", {61'd0, tx.n64d, tx.busy, tx.done}, 64'b100);
    repeat (3) @(negedge sys_clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    // Console command 0x01.
    send(64'h01, 8, 1'b0);
    check("cmd01_len", 64'(done_cyc - first_low), 64'(1650 + GUARD_CYC));
    check("cmd01_npulse", 64'(pulses.size()), 64'd9);
    check("cmd01_p0", 64'(pulse(0)), 64'd150);
    check("cmd01_p6", 64'(pulse(6)), 64'd150);
    check("cmd01_p7", 64'(pulse(7)), 64'd50);
    check("cmd01_stop", 64'(pulse(8)), 64'd50);

    // Controller reply 0x80000000 with controller stop.
    send(64'h8000_0000, 32, 1'b1);
    check("rep_len", 64'(done_cyc - first_low), 64'(6500 + GUARD_CYC));
    check("rep_npulse", 64'(pulses.size()), 64'd33);
    check("rep_p0", 64'(pulse(0)), 64'd50);
    check("rep_p1", 64'(pulse(1)), 64'd150);
    check("rep_p31", 64'(pulse(31)), 64'd150);
    check("rep_stop", 64'(pulse(32)), 64'd100);

    // Stop bit only.
    send(64'hFFFF, 0, 1'b0);
    check("n0_len", 64'(done_cyc - first_low), 64'(50 + GUARD_CYC));
    check("n0_npulse", 64'(pulses.size()), 64'd1);
    check("n0_p0", 64'(pulse(0)), 64'd50);

    // nbits above DATA_W clamps to 64.
    send({64{1'b1}}, 100, 1'b0);
    check("clamp_len", 64'(done_cyc - first_low), 64'(64 * 200 + 50 + GUARD_CYC));
    check("clamp_npulse", 64'(pulses.size()), 64'd65);
    check("clamp_p0", 64'(pulse(0)), 64'd50);
    check("clamp_p63", 64'(pulse(63)), 64'd50);

    // Starts while busy (including any guard) and on the done cycle are ignored.
    @(negedge sys_clk);
    tx.data = 64'h01; tx.nbits = 7'd8; tx.stop_sel = 1'b0; tx.start = 1'b1;
    @(negedge sys_clk);
    tx.start = 1'b0;
    k = 0;
    while (!tx.done && k < 20000) begin
      @(negedge sys_clk);
      k++;
      tx.start    = (k % 97 == 0);
      tx.data     = {$urandom, $urandom};
      tx.nbits    = 7'($urandom_range(0, 127));
      tx.stop_sel = 1'($urandom_range(0, 1));
    end
    check("busy_done_seen", {63'd0, tx.done}, 64'd1);
    tx.start = 1'b1;
    tx.data = 64'h3; tx.nbits = 7'd2; tx.stop_sel = 1'b1;
    @(negedge sys_clk);
    check("start_on_done_ignored", {63'd0, tx.busy}, 64'd0);
    @(negedge sys_clk);
    tx.start = 1'b0;
    check("restart_after_done", {62'd0, tx.busy, tx.n64d}, 64'b10);
    wait_done();
    repeat (5) @(negedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
